// File: rtl/cache_bus_arbiter_pkg.sv
// Shared bus/LSU types: arbiter state, beat counter width, request fields.
package cache_bus_arbiter_pkg;

  // 9 bits so a 256-beat burst (len=255) counts to 256 without wrapping.
  localparam int BEAT_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RDATA,
    ST_WDATA,
    ST_WRESP
  } arb_state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [7:0]  len;
  } cache_bus_req_t;

endpackage

// File: rtl/cache_bus_arbiter_pick.sv
// Priority + starvation picker: dcache wins ties unless icache has waited
// through STARVE_LIMIT consecutive dcache grants.
module bus_arb_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic       take,
  output logic       pick
);

  // +2 keeps the counter at least 1 bit wide even for STARVE_LIMIT=0.
  localparam int CW = $clog2(STARVE_LIMIT + 2);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  // Pick dcache (1) when it is valid, unless icache is valid and starved.
  always_comb begin
    starved = (starve_cnt == CW'(STARVE_LIMIT));
    pick    = req_valid[1] && !(req_valid[0] && starved);
  end

  // Count dcache grants taken over a waiting icache; clear on icache grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (take) begin
      if (!pick)
        starve_cnt <= '0;
      else if (req_valid[0] && !starved)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Two-requester (icache=0, dcache=1) burst arbiter onto one downstream bus.
// One burst in flight at a time; grants are only taken from IDLE.
module cache_bus_arbiter
  import cache_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       m_req_valid,
  output logic [1:0]       m_req_ready,
  input  logic [1:0]       m_req_write,
  input  logic [1:0][31:0] m_req_addr,
  input  logic [1:0][7:0]  m_req_len,
  input  logic [1:0]       m_wvalid,
  input  logic [1:0][31:0] m_wdata,
  input  logic [1:0][3:0]  m_wstrb,
  output logic [1:0]       m_wready,
  output logic [1:0]       m_rvalid,
  output logic [31:0]      m_rdata,
  output logic [1:0]       m_rlast,
  output logic [1:0]       m_bvalid,
  output logic             s_req_valid,
  input  logic             s_req_ready,
  output logic             s_req_write,
  output logic [31:0]      s_req_addr,
  output logic [7:0]       s_req_len,
  output logic             s_wvalid,
  output logic [31:0]      s_wdata,
  output logic [3:0]       s_wstrb,
  input  logic             s_wready,
  input  logic             s_rvalid,
  input  logic [31:0]      s_rdata,
  input  logic             s_rlast,
  input  logic             s_bvalid,
  output logic             busy_o
);

  arb_state_t         state;
  logic               gnt;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [7:0]         len_q;
  logic               take;
  logic               pick;
  logic               wbeat;
  logic [BEAT_W-1:0]  beat_nxt;
  cache_bus_req_t     req_g;

  bus_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk       (clk),
    .rst       (rst),
    .req_valid (m_req_valid),
    .take      (take),
    .pick      (pick)
  );

  // Granted request fields, handshake qualifiers and next beat count.
  always_comb begin
    take     = (state == ST_IDLE) && (|m_req_valid);
    req_g    = '{write: m_req_write[gnt], addr: m_req_addr[gnt], len: m_req_len[gnt]};
    wbeat    = (state == ST_WDATA) && m_wvalid[gnt] && s_wready;
    beat_nxt = beat_cnt + 1'b1;
  end

  // Burst sequencing FSM; len is captured at the address handshake since the
  // requester may change m_req_* once it has been accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= 1'b0;
      beat_cnt <= '0;
      len_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (take) begin
          gnt   <= pick;
          state <= ST_ADDR;
        end
        ST_ADDR: if (s_req_ready) begin
          len_q    <= req_g.len;
          beat_cnt <= '0;
          state    <= req_g.write ? ST_WDATA : ST_RDATA;
        end
        ST_RDATA: if (s_rvalid && s_rlast) state <= ST_IDLE;
        ST_WDATA: if (wbeat) begin
          if (beat_nxt == ({1'b0, len_q} + 1'b1)) begin
            beat_cnt <= '0;
            state    <= ST_WRESP;
          end else begin
            beat_cnt <= beat_nxt;
          end
        end
        ST_WRESP: if (s_bvalid) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Route the granted requester to the downstream bus; everything idles at 0
  // outside the phase that uses it, so stray downstream strobes are dropped.
  always_comb begin
    m_req_ready = '0;
    m_wready    = '0;
    m_rvalid    = '0;
    m_rlast     = '0;
    m_bvalid    = '0;
    m_rdata     = '0;
    s_req_valid = 1'b0;
    s_req_write = 1'b0;
    s_req_addr  = '0;
    s_req_len   = '0;
    s_wvalid    = 1'b0;
    s_wdata     = '0;
    s_wstrb     = '0;
    case (state)
      ST_ADDR: begin
        s_req_valid      = 1'b1;
        s_req_write      = req_g.write;
        s_req_addr       = req_g.addr;
        s_req_len        = req_g.len;
        m_req_ready[gnt] = s_req_ready;
      end
      ST_RDATA: begin
        m_rvalid[gnt] = s_rvalid;
        m_rlast[gnt]  = s_rlast;
        m_rdata       = s_rdata;
      end
      ST_WDATA: begin
        s_wvalid      = m_wvalid[gnt];
        s_wdata       = m_wdata[gnt];
        s_wstrb       = m_wstrb[gnt];
        m_wready[gnt] = s_wready;
      end
      ST_WRESP: m_bvalid[gnt] = s_bvalid;
      default: ;
    endcase
    busy_o = (state != ST_IDLE) || (|m_req_valid);
  end

endmodule
